// File: rtl/calc_pkg.sv
// Shared key codes, calculator function encoding and sequencer states for
// the calculator keypad front-end.
package calc_pkg;

    localparam logic [4:0] KEY_ADD    = 5'd16;
    localparam logic [4:0] KEY_SUB    = 5'd17;
    localparam logic [4:0] KEY_MUL    = 5'd18;
    localparam logic [4:0] KEY_DIV    = 5'd19;
    localparam logic [4:0] KEY_EQUALS = 5'd20;
    localparam logic [4:0] KEY_CLEAR  = 5'd21;

    typedef enum logic [1:0] {
        FN_ADD = 2'b00,
        FN_SUB = 2'b01,
        FN_MUL = 2'b10,
        FN_DIV = 2'b11
    } fn_e;

    typedef enum logic [2:0] {
        S_A,
        S_OP,
        S_B,
        S_EQ,
        S_EXEC,
        S_DONE
    } state_e;

    function automatic logic is_digit(input logic [4:0] code);
        return code[4] == 1'b0;
    endfunction

    function automatic logic is_operator(input logic [4:0] code);
        return code >= KEY_ADD && code <= KEY_DIV;
    endfunction

    // Operator codes 16..19 carry the function encoding in their low bits.
    function automatic fn_e key_to_fn(input logic [4:0] code);
        return fn_e'(code[1:0]);
    endfunction

endpackage

// File: rtl/calc_key_sequencer_if.sv
// Key stream handshake between the keypad scanner (master) and the
// sequencer (slave).
interface calc_key_sequencer_if;
    logic       key_valid;
    logic [4:0] key_code;
    logic       key_ready;

    modport master (output key_valid, output key_code, input  key_ready);
    modport slave  (input  key_valid, input  key_code, output key_ready);
endinterface

// File: rtl/calc_key_sequencer.sv
// Assembles operand A, operator and operand B from key presses, drives the
// external combinational calculator and captures its result for display.
module calc_key_sequencer
    import calc_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    calc_key_sequencer_if.slave         kif,
    output logic [3:0]                  calc_a,
    output logic [3:0]                  calc_b,
    output logic [1:0]                  calc_fn,
    input  logic [7:0]                  calc_result,
    output logic [7:0]                  result,
    output logic                        result_valid,
    output logic                        error,
    output logic [7:0]                  op_count
);

    state_e     state_q, state_d;
    logic [3:0] calc_a_q, calc_a_d;
    logic [3:0] calc_b_q, calc_b_d;
    fn_e        calc_fn_q, calc_fn_d;
    logic [7:0] result_q, result_d;
    logic       result_valid_q, result_valid_d;
    logic       error_q, error_d;
    logic [7:0] op_count_q, op_count_d;

    logic key_ready;
    logic accept;
    logic key_digit;
    logic key_op;
    logic key_eq;
    logic key_clr;

    // The one-cycle stall in S_EXEC keeps the operands frozen while the
    // calculator output is captured.
    assign key_ready     = (state_q != S_EXEC);
    assign kif.key_ready = key_ready;
    assign accept        = kif.key_valid && key_ready;
    assign key_digit     = accept && is_digit(kif.key_code);
    assign key_op        = accept && is_operator(kif.key_code);
    assign key_eq        = accept && (kif.key_code == KEY_EQUALS);
    assign key_clr       = accept && (kif.key_code == KEY_CLEAR);

    // NOTE: every _d signal gets its hold value first so no path through the
    // case statement leaves it unassigned and infers a latch.
    always_comb begin
        state_d        = state_q;
        calc_a_d       = calc_a_q;
        calc_b_d       = calc_b_q;
        calc_fn_d      = calc_fn_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        error_d        = error_q;
        op_count_d     = op_count_q;

        unique case (state_q)
            S_A: begin
                if (key_digit) begin
                    calc_a_d = kif.key_code[3:0];
                    state_d  = S_OP;
                end
            end
            S_OP: begin
                if (key_digit) begin
                    calc_a_d = kif.key_code[3:0];
                end else if (key_op) begin
                    calc_fn_d = key_to_fn(kif.key_code);
                    state_d   = S_B;
                end
            end
            S_B: begin
                if (key_digit) begin
                    calc_b_d = kif.key_code[3:0];
                    state_d  = S_EQ;
                end else if (key_op) begin
                    calc_fn_d = key_to_fn(kif.key_code);
                end
            end
            S_EQ: begin
                if (key_digit) begin
                    calc_b_d = kif.key_code[3:0];
                end else if (key_eq) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Divide-by-zero is flagged here rather than trusting the
                // calculator's output for that case.
                if (calc_fn_q == FN_DIV && calc_b_q == 4'd0) begin
                    result_d = 8'hFF;
                    error_d  = 1'b1;
                end else begin
                    result_d = calc_result;
                    error_d  = 1'b0;
                end
                result_valid_d = 1'b1;
                if (op_count_q != 8'hFF) begin
                    op_count_d = op_count_q + 8'd1;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (key_digit) begin
                    calc_a_d       = kif.key_code[3:0];
                    result_valid_d = 1'b0;
                    error_d        = 1'b0;
                    state_d        = S_OP;
                end else if (key_op) begin
                    calc_a_d       = result_q[3:0];
                    calc_fn_d      = key_to_fn(kif.key_code);
                    result_valid_d = 1'b0;
                    error_d        = 1'b0;
                    state_d        = S_B;
                end
            end
            default: state_d = S_A;
        endcase

        // accept is never true in S_EXEC, so CLEAR cannot abort a capture.
        if (key_clr) begin
            calc_a_d       = 4'd0;
            calc_b_d       = 4'd0;
            calc_fn_d      = FN_ADD;
            result_d       = 8'd0;
            result_valid_d = 1'b0;
            error_d        = 1'b0;
            state_d        = S_A;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_A;
            calc_a_q       <= 4'd0;
            calc_b_q       <= 4'd0;
            calc_fn_q      <= FN_ADD;
            result_q       <= 8'd0;
            result_valid_q <= 1'b0;
            error_q        <= 1'b0;
            op_count_q     <= 8'd0;
        end else begin
            state_q        <= state_d;
            calc_a_q       <= calc_a_d;
            calc_b_q       <= calc_b_d;
            calc_fn_q      <= calc_fn_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            error_q        <= error_d;
            op_count_q     <= op_count_d;
        end
    end

    assign calc_a       = calc_a_q;
    assign calc_b       = calc_b_q;
    assign calc_fn      = calc_fn_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign error        = error_q;
    assign op_count     = op_count_q;

endmodule

// File: doc/calc_key_sequencer.md
# calc_key_sequencer

Sequential front-end for the 4-bit combinational calculator. It accepts a stream of key codes (digits, operators, equals, clear) over a valid/ready handshake and assembles operand A, the operator and operand B. It then drives the calculator's operand/function inputs, captures the 8-bit result and holds it for display. It sits between the keypad scanner and the calculator datapath, and supports chained operations on the previous result.

## Interface
Parameters:
- none (all widths fixed by the calculator datapath: 4-bit operands, 2-bit function, 8-bit result)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- key_valid  in  1  key_code is valid this cycle
- key_code  in  5  0–15 hex digit; 16 ADD, 17 SUB, 18 MUL, 19 DIV, 20 EQUALS, 21 CLEAR; 22–31 reserved
- key_ready  out  1  sequencer can accept a key
- calc_a  out  4  operand A to calculator (registered)
- calc_b  out  4  operand B to calculator (registered)
- calc_fn  out  2  function to calculator: 00 add, 01 sub, 10 mul, 11 div (registered)
- calc_result  in  8  combinational result from calculator
- result  out  8  captured result
- result_valid  out  1  result holds a completed operation
- error  out  1  last operation was divide-by-zero
- op_count  out  8  completed operations, saturates at 255

## Operation
- A key is accepted when key_valid && key_ready. Unaccepted keys are not consumed; key_code must be held until accepted.
- Reserved codes are accepted and ignored in every state.
- States and transitions:
  - S_A: digit → calc_a=digit, go S_OP. Operator/EQUALS ignored.
  - S_OP: digit → overwrite calc_a, stay. Operator → calc_fn, go S_B. EQUALS ignored.
  - S_B: digit → calc_b, go S_EQ. Operator → overwrite calc_fn, stay. EQUALS ignored.
  - S_EQ: digit → overwrite calc_b, stay. EQUALS → S_EXEC. Operator ignored.
  - S_EXEC: key_ready=0 for exactly one cycle.
    - Divide-by-zero (calc_fn=11, calc_b=0): result=8'hFF, error=1.
    - Otherwise: result=calc_result, error=0.
    - result_valid=1, op_count+1 saturating, then go S_DONE.
  - S_DONE: digit → calc_a=digit, result_valid=0, error=0, go S_OP.
    - Operator → chain: calc_a=result[3:0], calc_fn=op, result_valid=0, error=0, go S_B.
    - EQUALS ignored; result held.
- CLEAR in any state except S_EXEC: calc_a, calc_b, calc_fn, result, result_valid and error go to 0, then S_A. op_count is kept.
- calc_result is consumed unmodified. Subtraction wraps in 8 bits (3−5 → 8'hFE). Multiply is at most 8'hE1.

## Timing
- Reset values:
  - key_ready=1
  - calc_a, calc_b, calc_fn = 0
  - result=0, result_valid=0, error=0, op_count=0
  - state=S_A
- calc_a, calc_b and calc_fn are stable from the edge that accepts the last digit through S_EXEC, so the combinational calculator has settled by the capture edge.
- EQUALS accepted at edge N: S_EXEC during cycle N+1 with key_ready=0; result, result_valid and error update at edge N+1. Latency is 2 edges.
- A key presented during S_EXEC stalls one cycle and is accepted at the next edge.
- Only one key is consumed per cycle.
- Asynchronous reset mid-entry or during S_EXEC aborts immediately. No partial result is retained.

## Structure
- Shared package calc_pkg:
  - key code constants (KEY_ADD … KEY_CLEAR)
  - function enum (FN_ADD=2'b00, FN_SUB, FN_MUL, FN_DIV)
  - state enum (S_A, S_OP, S_B, S_EQ, S_EXEC, S_DONE)
- Single module with one FSM, operand/function registers and the result/op_count registers. No sub-module.
- The calculator stays external and is wired alongside in the testbench/top.

## Test plan
- Keys 3, ADD, 5, EQUALS → calc_fn=00; two edges after EQUALS: result=8'h08, result_valid=1, error=0, op_count=1.
- Keys 7, MUL, F, EQUALS → result=8'h69. 3, SUB, 5, EQUALS → result=8'hFE.
- Keys 9, DIV, 0, EQUALS → result=8'hFF, error=1. Next digit 4 → error=0, result_valid=0, calc_a=4.
- Keys 2, ADD, 3, EQUALS, then MUL, 4, EQUALS → calc_a=5 after chain, final result=8'h14, op_count=2.
- Hold key_valid with EQUALS then digit 1 continuously → key_ready low exactly one cycle in S_EXEC; digit 1 accepted the following edge, calc_a=1.
- Keys 6, SUB then CLEAR → state S_A, all outputs 0 except op_count. Assert rst mid-entry → all reset values immediately, without waiting for a clock edge.
